// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store sequencer in front of a single-port RAM with registered read data.
// Sub-word stores are done as read-modify-write, and misaligned or illegal requests are answered immediately.
module mem_access_unit #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] ram_address,
  output logic [31:0]       ram_data_input,
  output logic              ram_store,
  output logic              ram_load,
  input  logic [31:0]       ram_data_output
);
  typedef enum logic [2:0] {IDLE, RD, LDCAP, WR, RESP} state_t;
  state_t state_q, state_d;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              err_q;
  logic              accept, mis, ill, bad;
  logic [4:0]        shamt;
  logic [31:0]       lane, load_ext, mask, merged;
  assign accept = req_valid && state_q == IDLE;
  assign mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign ill = req_write ? req_funct3 > 3'b010
                         : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign bad = mis || ill;
  // funct3[2] marks the unsigned loads; funct3[1:0] encodes byte/half/word
  assign shamt    = {addr_q[1:0], 3'b000};
  assign lane     = ram_data_output >> shamt;
  assign load_ext = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & lane[7]}}, lane[7:0]} :
                    funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} :
                    ram_data_output;
  assign mask     = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign merged   = funct3_q[1] ? wdata_q
                                : (ram_data_output & ~mask) | ((wdata_q << shamt) & mask);
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_valid) state_d = bad ? RESP : (req_write && req_funct3 == 3'b010) ? WR : RD;
      RD:        state_d = write_q ? WR : LDCAP;
      LDCAP, WR: state_d = RESP;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready      = state_q == IDLE;
    ram_load       = state_q == RD;
    ram_store      = state_q == WR;
    resp_valid     = state_q == RESP;
    ram_data_input = ram_store ? merged : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (bad) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end
      end
      if (state_q == LDCAP) rdata_q <= load_ext;
      if (state_q == LDCAP || state_q == WR) err_q <= 1'b0;
    end
  end
  assign ram_address = addr_q[ADDR_W-1:2];
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector bench for mem_access_unit with a behavioural registered-read RAM.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [13:0] req_addr = 14'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] ram_address;
  logic [31:0] ram_data_input;
  logic        ram_store;
  logic        ram_load;
  logic [31:0] ram_data_output = 32'h0;
  logic [31:0] mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_a = 12'h0;
  logic [31:0] bd_d = 32'h0;
  int          errors = 0;
  int          checks = 0;
  int          lat;
  logic [31:0] rd;
  logic        e, ld, st;
  logic [11:0] sa;
  logic [8:1]  rv, rr;
  int          nst;
  logic        any_rv;

  mem_access_unit #(.ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_address(ram_address), .ram_data_input(ram_data_input), .ram_store(ram_store),
    .ram_load(ram_load), .ram_data_output(ram_data_output)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else begin
      if (ram_store) mem[ram_address] <= ram_data_input;
      if (ram_load) ram_data_output <= mem[ram_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_a  = a;
    bd_d  = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one request from IDLE and watch strobes until the response pulse (bounded)
  task automatic xact(input logic w, input logic [2:0] f3, input logic [13:0] a, input logic [31:0] wd,
                      output int l, output logic [31:0] r, output logic er,
                      output logic sl, output logic ss, output logic [11:0] saddr);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 0; r = 32'h0; er = 1'b0; sl = 1'b0; ss = 1'b0; saddr = 12'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_load && ram_store) check("strobe_overlap", 1, 0);
      sl |= ram_load;
      if (ram_store) begin
        ss = 1'b1;
        saddr = ram_address;
      end
      if (resp_valid) begin
        l = k; r = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  initial begin
    // reset held with a request pending: reset must win
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 14'h030; req_wdata = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_store", ram_store, 0);
    check("rst_resp", resp_valid, 0);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_load", ram_load, 0);
    check("rst_addr", ram_address, 0);
    check("rst_din", ram_data_input, 0);
    check("rst_mem", mem[12], 0);

    xact(1, 3'b010, 14'h010, 32'hDEADBEEF, lat, rd, e, ld, st, sa);
    check("sw_lat", lat, 2);
    check("sw_store", st, 1);
    check("sw_load", ld, 0);
    check("sw_addr", sa, 12'h004);
    check("sw_err", e, 0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    xact(0, 3'b010, 14'h010, 32'h0, lat, rd, e, ld, st, sa);
    check("lw_lat", lat, 3);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", e, 0);
    check("lw_store", st, 0);

    poke(12'h004, 32'h11223344);
    xact(1, 3'b000, 14'h012, 32'h000000AB, lat, rd, e, ld, st, sa);
    check("sb_lat", lat, 3);
    check("sb_mem", mem[4], 32'h11AB3344);
    check("sb_keep_rdata", rd, 32'hDEADBEEF);
    check("sb_err", e, 0);
    poke(12'h001, 32'hAABBCCDD);
    xact(1, 3'b001, 14'h006, 32'hFFFF1234, lat, rd, e, ld, st, sa);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[1], 32'h1234CCDD);

    poke(12'h000, 32'h80FF7F01);
    xact(0, 3'b000, 14'h002, 32'h0, lat, rd, e, ld, st, sa);
    check("lb", rd, 32'hFFFFFFFF);
    xact(0, 3'b100, 14'h002, 32'h0, lat, rd, e, ld, st, sa);
    check("lbu", rd, 32'h000000FF);
    xact(0, 3'b001, 14'h002, 32'h0, lat, rd, e, ld, st, sa);
    check("lh", rd, 32'hFFFF80FF);
    xact(0, 3'b101, 14'h000, 32'h0, lat, rd, e, ld, st, sa);
    check("lhu", rd, 32'h00007F01);
    xact(0, 3'b000, 14'h001, 32'h0, lat, rd, e, ld, st, sa);
    check("lb_pos", rd, 32'h0000007F);
    xact(0, 3'b000, 14'h003, 32'h0, lat, rd, e, ld, st, sa);
    check("lb_b3", rd, 32'hFFFFFF80);

    xact(0, 3'b010, 14'h013, 32'h0, lat, rd, e, ld, st, sa);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_err", e, 1);
    check("lw_mis_rdata", rd, 0);
    check("lw_mis_strobe", {ld, st}, 0);
    xact(1, 3'b001, 14'h011, 32'h0000BEEF, lat, rd, e, ld, st, sa);
    check("sh_mis_lat", lat, 1);
    check("sh_mis_err", e, 1);
    check("sh_mis_strobe", {ld, st}, 0);
    check("sh_mis_mem", mem[4], 32'h11AB3344);
    xact(0, 3'b011, 14'h000, 32'h0, lat, rd, e, ld, st, sa);
    check("ld_ill_err", e, 1);
    check("ld_ill_strobe", {ld, st}, 0);
    xact(1, 3'b100, 14'h000, 32'h0, lat, rd, e, ld, st, sa);
    check("st_ill_err", e, 1);
    check("st_ill_mem", mem[0], 32'h80FF7F01);
    @(negedge clk);
    check("err_hold", resp_err, 1);
    xact(0, 3'b010, 14'h000, 32'h0, lat, rd, e, ld, st, sa);
    check("err_clear", e, 0);

    // three SW with req_valid held high: responses 3 cycles apart, ready only in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 14'h020; req_wdata = 32'h0BADF00D;
    rv = '0; rr = '0; nst = 0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rv[k] = resp_valid;
      rr[k] = req_ready;
      if (ram_store) nst++;
    end
    req_valid = 1'b0;
    check("b2b_resp", rv, 8'b10010010);
    check("b2b_ready", rr, 8'b00100100);
    check("b2b_stores", nst, 3);
    check("b2b_mem", mem[8], 32'h0BADF00D);

    // reset during the read phase of a SH: no write, no response
    poke(12'h005, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 14'h014; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_in_rd", ram_load, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rdrst_ready", req_ready, 1);
    any_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      any_rv |= resp_valid | ram_store;
    end
    check("rdrst_quiet", any_rv, 0);
    check("rdrst_mem", mem[5], 32'h11223344);

    // reset during WR: the write on that edge still lands
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 14'h018; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wr_state", ram_store, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    any_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      any_rv |= resp_valid;
    end
    check("wrrst_noresp", any_rv, 0);
    check("wrrst_mem", mem[6], 32'h00000055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
